lcd_ctrl: RTL and testbench

Memory-mapped HD44780-style character LCD controller. It sits between the LSU's LCD output register (o_io_lcd, address 0x7030) and the LCD pins. When software flips a toggle bit in the register, the block runs one bus write with correct setup, enable-pulse and hold timing, then waits out the command execution time. A status word reports busy and acknowledge state so software can poll before issuing the next write.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_ctrl.sv | 141 ++++++++++++++
 tb/tb_lcd_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD controller.
// Holds the FSM state enum, LCD register bit positions, command codes and status bits.
// No logic lives here; it is imported by lcd_ctrl.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  // Bit positions inside the LSU LCD register
  localparam int LCD_ON_BIT  = 31;
  localparam int LCD_RS_BIT  = 10;
  localparam int LCD_TGL_BIT = 8;

  // Commands that need the long execution wait (0x03 also decodes as home)
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
  localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

  // Bit positions inside the status word
  localparam int LCD_STAT_BUSY_BIT = 0;
  localparam int LCD_STAT_ACK_BIT  = 8;

  // True when a latched write is a clear/home command
  function automatic logic lcd_is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME || data == LCD_CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// Memory-mapped character LCD controller: turns a TGL flip into one timed bus write.
// Latency: EN rises P_SETUP cycles after accept; busy lasts SETUP+PULSE+HOLD+exec wait.
// Backpressure: TGL flips while busy are not sampled; software polls status before writing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int P_SETUP = 2,
  parameter int P_PULSE = 12,
  parameter int P_HOLD  = 2,
  parameter int P_EXEC  = 2000,
  parameter int P_CLEAR = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lcd_reg,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic [31:0] o_lcd_status
);

  localparam int CW = $clog2(P_CLEAR);

  lcd_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          ack_q;
  logic          on_q;
  logic          rs_q;
  logic          en_q;
  logic [7:0]    data_q;
  logic          busy_q;
  logic [31:0]   status_d;

  logic reg_on;
  logic reg_rs;
  logic reg_tgl;
  logic unused_reg_bits;

  assign reg_on  = i_lcd_reg[LCD_ON_BIT];
  assign reg_rs  = i_lcd_reg[LCD_RS_BIT];
  assign reg_tgl = i_lcd_reg[LCD_TGL_BIT];
  assign unused_reg_bits = ^{i_lcd_reg[30:11], i_lcd_reg[9]};

  // Transfer FSM with inline down-counter; all pin-facing outputs are registered here
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      on_q    <= 1'b0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      on_q <= reg_on;
      if (state_q != ST_IDLE && !reg_on) begin
        // Power dropped mid-transfer: abandon the cycle, keep ack as accepted
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (reg_tgl != ack_q) begin
              ack_q <= reg_tgl;
              // Writes while the panel is off are acknowledged but dropped
              if (reg_on) begin
                rs_q    <= reg_rs;
                data_q  <= i_lcd_reg[7:0];
                busy_q  <= 1'b1;
                state_q <= ST_SETUP;
                cnt_q   <= CW'(P_SETUP - 1);
              end
            end
          end
          ST_SETUP: begin
            if (cnt_q == '0) begin
              state_q <= ST_PULSE;
              en_q    <= 1'b1;
              cnt_q   <= CW'(P_PULSE - 1);
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_PULSE: begin
            if (cnt_q == '0) begin
              state_q <= ST_HOLD;
              en_q    <= 1'b0;
              cnt_q   <= CW'(P_HOLD - 1);
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_HOLD: begin
            if (cnt_q == '0) begin
              state_q <= ST_WAIT;
              if (lcd_is_long_cmd(rs_q, data_q)) cnt_q <= CW'(P_CLEAR - 1);
              else                               cnt_q <= CW'(P_EXEC - 1);
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_WAIT: begin
            if (cnt_q == '0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Status word assembled from registered busy/ack only
  always_comb begin
    status_d = '0;
    status_d[LCD_STAT_BUSY_BIT] = busy_q;
    status_d[LCD_STAT_ACK_BIT]  = ack_q;
  end

  assign o_lcd_on     = on_q;
  assign o_lcd_rs     = rs_q;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_en     = en_q;
  assign o_lcd_data   = data_q;
  assign o_busy       = busy_q;
  assign o_lcd_status = status_d;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl with shortened exec/clear waits.
// Each scenario task drives the register and checks outputs #1 after the clock edge.
// Expected cycle counts come from the timing parameters below.
module tb_lcd_ctrl;

  localparam int P_SETUP = 2;
  localparam int P_PULSE = 12;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 40;
  localparam int P_CLEAR = 300;
  localparam int XFER    = P_SETUP + P_PULSE + P_HOLD;
  localparam int LIMIT   = XFER + P_CLEAR + 50;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [31:0] i_lcd_reg = 32'h0;
  logic        o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_busy;
  logic [7:0]  o_lcd_data;
  logic [31:0] o_lcd_status;

  int checks = 0;
  int errors = 0;
  logic ack_m = 1'b0;

  lcd_ctrl #(
    .P_SETUP(P_SETUP), .P_PULSE(P_PULSE), .P_HOLD(P_HOLD),
    .P_EXEC(P_EXEC), .P_CLEAR(P_CLEAR)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_lcd_reg(i_lcd_reg),
    .o_lcd_on(o_lcd_on), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_en(o_lcd_en), .o_lcd_data(o_lcd_data), .o_busy(o_busy),
    .o_lcd_status(o_lcd_status)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Build a register value; bits 19:12 carry junk that the block must ignore
  function automatic logic [31:0] mk(input logic on, input logic rs, input logic tgl, input logic [7:0] d);
    logic [31:0] r;
    r = 32'h0;
    r[19:12] = 8'hA5;
    r[31] = on;
    r[10] = rs;
    r[8]  = tgl;
    r[7:0] = d;
    return r;
  endfunction

  // First tick is the accept edge; then observe until busy falls (at least 20 cycles).
  // Optional register changes are applied after the sample at cycle m1_k / m2_k.
  task automatic run_xfer(input int m1_k, input logic [31:0] m1_r,
                          input int m2_k, input logic [31:0] m2_r,
                          output int busy_c, output int en_start,
                          output int en_len, output int pulses);
    logic prev;
    busy_c = 0; en_start = -1; en_len = 0; pulses = 0; prev = 1'b0;
    tick();
    for (int k = 0; k < LIMIT; k++) begin
      if (!o_busy && k >= 20) break;
      if (o_busy) busy_c++;
      if (o_lcd_en) begin
        en_len++;
        if (!prev) begin
          pulses++;
          if (en_start < 0) en_start = k;
        end
      end
      prev = o_lcd_en;
      if (k == m1_k) i_lcd_reg = m1_r;
      if (k == m2_k) i_lcd_reg = m2_r;
      tick();
    end
  endtask

  task automatic test_reset();
    int b, s, l, p;
    i_rst = 1'b0;
    i_lcd_reg = 32'h8000_01FF;
    repeat (3) tick();
    checks++; if (o_lcd_on !== 1'b0) begin errors++; $display("FAIL rst_on got %b want 0", o_lcd_on); end
    checks++; if (o_lcd_rs !== 1'b0) begin errors++; $display("FAIL rst_rs got %b want 0", o_lcd_rs); end
    checks++; if (o_lcd_rw !== 1'b0) begin errors++; $display("FAIL rst_rw got %b want 0", o_lcd_rw); end
    checks++; if (o_lcd_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b want 0", o_lcd_en); end
    checks++; if (o_lcd_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", o_lcd_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", o_busy); end
    checks++; if (o_lcd_status !== 32'h0) begin errors++; $display("FAIL rst_status got %h want 0", o_lcd_status); end
    // TGL now equals ack=0: no transfer may start after release
    i_lcd_reg = 32'h8000_0000;
    i_rst = 1'b1;
    run_xfer(-1, 32'h0, -1, 32'h0, b, s, l, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL rst_idle_pulses got %0d want 0", p); end
    checks++; if (b !== 0) begin errors++; $display("FAIL rst_idle_busy got %0d want 0", b); end
    checks++; if (o_lcd_on !== 1'b1) begin errors++; $display("FAIL rst_on_follow got %b want 1", o_lcd_on); end
  endtask

  task automatic test_data_write();
    int b, s, l, p;
    i_lcd_reg = 32'h8000_0541;
    run_xfer(-1, 32'h0, -1, 32'h0, b, s, l, p);
    ack_m = 1'b1;
    checks++; if (o_lcd_rs !== 1'b1) begin errors++; $display("FAIL wr_rs got %b want 1", o_lcd_rs); end
    checks++; if (o_lcd_data !== 8'h41) begin errors++; $display("FAIL wr_data got %h want 41", o_lcd_data); end
    checks++; if (s !== P_SETUP) begin errors++; $display("FAIL wr_en_start got %0d want %0d", s, P_SETUP); end
    checks++; if (l !== P_PULSE) begin errors++; $display("FAIL wr_en_len got %0d want %0d", l, P_PULSE); end
    checks++; if (p !== 1) begin errors++; $display("FAIL wr_pulses got %0d want 1", p); end
    checks++; if (b !== XFER + P_EXEC) begin errors++; $display("FAIL wr_busy got %0d want %0d", b, XFER + P_EXEC); end
    checks++; if (o_lcd_status !== 32'h0000_0100) begin errors++; $display("FAIL wr_status got %h want 00000100", o_lcd_status); end
  endtask

  task automatic test_cmd_wait();
    logic       rs_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] d_t  [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h01};
    int         w_t  [6] = '{P_CLEAR, P_CLEAR, P_CLEAR, P_EXEC, P_EXEC, P_EXEC};
    int b, s, l, p;
    for (int i = 0; i < 6; i++) begin
      ack_m = ~ack_m;
      i_lcd_reg = mk(1'b1, rs_t[i], ack_m, d_t[i]);
      run_xfer(-1, 32'h0, -1, 32'h0, b, s, l, p);
      checks++; if (b !== XFER + w_t[i]) begin errors++; $display("FAIL cmd%0d_busy got %0d want %0d", i, b, XFER + w_t[i]); end
      checks++; if (o_lcd_data !== d_t[i] || o_lcd_rs !== rs_t[i]) begin errors++; $display("FAIL cmd%0d_bus got rs=%b data=%h want rs=%b data=%h", i, o_lcd_rs, o_lcd_data, rs_t[i], d_t[i]); end
      checks++; if (o_lcd_status !== {23'b0, ack_m, 8'b0}) begin errors++; $display("FAIL cmd%0d_status got %h want ack=%b", i, o_lcd_status, ack_m); end
    end
  endtask

  task automatic test_pending();
    int b, s, l, p;
    logic t;
    t = ~ack_m;
    i_lcd_reg = mk(1'b1, 1'b1, t, 8'h41);
    run_xfer(30, mk(1'b1, 1'b1, ~t, 8'h42), -1, 32'h0, b, s, l, p);
    checks++; if (b !== XFER + P_EXEC || o_lcd_data !== 8'h41) begin errors++; $display("FAIL pend_first got busy=%0d data=%h want %0d 41", b, o_lcd_data, XFER + P_EXEC); end
    // Pending write must be accepted on the very next edge
    run_xfer(-1, 32'h0, -1, 32'h0, b, s, l, p);
    ack_m = ~t;
    checks++; if (o_lcd_data !== 8'h42) begin errors++; $display("FAIL pend_data got %h want 42", o_lcd_data); end
    checks++; if (b !== XFER + P_EXEC || s !== P_SETUP) begin errors++; $display("FAIL pend_second got busy=%0d en_start=%0d want %0d %0d", b, s, XFER + P_EXEC, P_SETUP); end
    // Two flips during busy cancel out
    t = ~ack_m;
    i_lcd_reg = mk(1'b1, 1'b0, t, 8'h43);
    run_xfer(10, mk(1'b1, 1'b0, ~t, 8'h44), 30, mk(1'b1, 1'b0, t, 8'h45), b, s, l, p);
    ack_m = t;
    checks++; if (p !== 1 || o_lcd_data !== 8'h43) begin errors++; $display("FAIL dbl_first got pulses=%0d data=%h want 1 43", p, o_lcd_data); end
    run_xfer(-1, 32'h0, -1, 32'h0, b, s, l, p);
    checks++; if (p !== 0 || b !== 0) begin errors++; $display("FAIL dbl_none got pulses=%0d busy=%0d want 0 0", p, b); end
  endtask

  task automatic test_power_off();
    int b, s, l, p;
    logic t;
    t = ~ack_m;
    i_lcd_reg = mk(1'b0, 1'b1, t, 8'h66);
    run_xfer(-1, 32'h0, -1, 32'h0, b, s, l, p);
    ack_m = t;
    checks++; if (p !== 0 || b !== 0) begin errors++; $display("FAIL off_xfer got pulses=%0d busy=%0d want 0 0", p, b); end
    checks++; if (o_lcd_status !== {23'b0, t, 8'b0}) begin errors++; $display("FAIL off_ack got %h want ack=%b", o_lcd_status, t); end
    checks++; if (o_lcd_on !== 1'b0 || o_lcd_data !== 8'h43) begin errors++; $display("FAIL off_pins got on=%b data=%h want 0 43", o_lcd_on, o_lcd_data); end
    // Power back on: the dropped write is not replayed
    i_lcd_reg = mk(1'b1, 1'b1, t, 8'h66);
    run_xfer(-1, 32'h0, -1, 32'h0, b, s, l, p);
    checks++; if (p !== 0 || b !== 0 || o_lcd_on !== 1'b1) begin errors++; $display("FAIL on_noreplay got pulses=%0d busy=%0d on=%b want 0 0 1", p, b, o_lcd_on); end
    // Drop ON during the enable pulse
    t = ~ack_m;
    i_lcd_reg = mk(1'b1, 1'b1, t, 8'h77);
    run_xfer(5, mk(1'b0, 1'b1, t, 8'h77), -1, 32'h0, b, s, l, p);
    ack_m = t;
    checks++; if (b !== 6 || l !== 4) begin errors++; $display("FAIL abort_timing got busy=%0d en_len=%0d want 6 4", b, l); end
    checks++; if (o_lcd_en !== 1'b0 || o_busy !== 1'b0 || o_lcd_on !== 1'b0) begin errors++; $display("FAIL abort_pins got en=%b busy=%b on=%b want 0 0 0", o_lcd_en, o_busy, o_lcd_on); end
    checks++; if (o_lcd_status !== {23'b0, t, 8'b0} || o_lcd_data !== 8'h77) begin errors++; $display("FAIL abort_state got status=%h data=%h want ack=%b 77", o_lcd_status, o_lcd_data, t); end
  endtask

  task automatic test_reset_mid_wait();
    int b, s, l, p;
    if (ack_m) begin
      i_lcd_reg = mk(1'b0, 1'b0, 1'b0, 8'h00);
      tick(); tick();
      ack_m = 1'b0;
    end
    i_lcd_reg = mk(1'b1, 1'b1, 1'b1, 8'h55);
    tick();
    repeat (29) tick();
    checks++; if (o_busy !== 1'b1 || o_lcd_en !== 1'b0) begin errors++; $display("FAIL mid_wait got busy=%b en=%b want 1 0", o_busy, o_lcd_en); end
    i_rst = 1'b0;
    tick();
    checks++; if ({o_lcd_on, o_lcd_rs, o_lcd_en, o_busy, o_lcd_data} !== 12'h0 || o_lcd_status !== 32'h0) begin errors++; $display("FAIL mid_rst got on=%b rs=%b en=%b busy=%b data=%h status=%h want all 0", o_lcd_on, o_lcd_rs, o_lcd_en, o_busy, o_lcd_data, o_lcd_status); end
    i_rst = 1'b1;
    run_xfer(-1, 32'h0, -1, 32'h0, b, s, l, p);
    ack_m = 1'b1;
    checks++; if (b !== XFER + P_EXEC || p !== 1 || o_lcd_data !== 8'h55) begin errors++; $display("FAIL mid_fresh got busy=%0d pulses=%0d data=%h want %0d 1 55", b, p, o_lcd_data, XFER + P_EXEC); end
    checks++; if (o_lcd_status !== 32'h0000_0100) begin errors++; $display("FAIL mid_status got %h want 00000100", o_lcd_status); end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_cmd_wait();
    test_pending();
    test_power_off();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
